icache_meta_array: RTL and testbench
====================================

# icache_meta_array

- Tag and valid metadata store for the 8-way, 64-set instruction cache; the responder for the lookup stage's read requests.
- Returns all eight tags (8×44 bits) and the 8-bit valid vector of a set, one cycle after a read request is accepted.
- Also takes refill writes, single-way invalidates, and a full-cache flush. The flush is a 64-cycle sweep run by a small FSM.

## Interface
Parameters
- SETS, 64, number of sets (index width log2(SETS)=6)
- WAYS, 8, associativity (way width 3)
- TAG_W, 44, physical tag width

Ports
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- lookup2meta_valid  in  1  read request
- lookup2meta_index  in  6  set to read
- lookup2meta_ready  in  1  downstream may advance; a read is accepted when valid && ready && !meta2lookup_busy
- meta2lookup_rvalid  out  1  read data registers hold an accepted read result
- meta2lookup_valid_rdata  out  8  valid bits of the read set; bit w = way w
- meta2lookup_tag_rdata  out  352  tags of the read set; way w at [44w+43:44w]
- meta2lookup_busy  out  1  flush in progress
- refill2meta_wen  in  1  write a tag and set its valid bit
- refill2meta_index  in  6  / refill2meta_way  in  3  / refill2meta_tag  in  44
- inv2meta_en  in  1  clear one valid bit
- inv2meta_index  in  6  / inv2meta_way  in  3
- inv2meta_ready  out  1  invalidate accepted this cycle
- flush_req  in  1  single-cycle pulse: invalidate the whole cache
- flush_done  out  1  one-cycle pulse when the sweep completes

## Operation
Storage
- Valid bits: 64×8 flops, cleared by reset.
- Tags: 64×352 register array, not reset.

Write priority (at most one set is written per cycle)
- Highest: the flush sweep.
- Then refill.
- Then invalidate.
- inv2meta_ready = inv2meta_en && !refill2meta_wen && !busy. The requester must hold inv2meta_en until it sees ready.

Refill
- tag[index][way] <= refill2meta_tag.
- valid[index][way] <= 1.
- Refill asserted while busy is dropped; the controller must not refill during a flush.

Invalidate
- valid[index][way] <= 0. Tags are untouched.

Read
- On accept, the output registers capture that set's valid and tag data, and rvalid is set.
- With no accept, the outputs hold their value. rvalid is cleared only by reset or by the start of a flush.
- Same-cycle write to the set being read: the read returns post-write data, per way (bypass). This applies to both the tag and the valid bit.

Flush FSM
- IDLE: flush_req → FLUSH, counter=0, busy=1, rvalid<=0.
- FLUSH: each cycle, valid[counter] <= 0, then counter++.
  - At counter==63: clear set 63, pulse flush_done, → IDLE (busy=0 next cycle).
  - flush_req during FLUSH is ignored.
- Read requests are not accepted while busy=1.

## Timing
Reset values
- rvalid=0, valid_rdata=0, tag_rdata=0, busy=0, flush_done=0, inv2meta_ready=0, FSM=IDLE, counter=0, all valid bits 0.
- Reset mid-flush returns the FSM to IDLE with all valids already cleared; no flush_done pulse is generated.

Read
- Latency 1: a request accepted in cycle N has its data on the outputs in cycle N+1.
- Back-to-back accepts are allowed, giving full throughput.

Writes
- Refill and invalidate take effect at the clock edge.
- A read accepted in the following cycle sees the new data.

Flush
- flush_req in cycle N: busy=1 in cycles N+1 … N+64.
- flush_done pulses in cycle N+64.
- busy=0 in N+65; the first read can be accepted in N+65.

## Structure
- Shared package icache_pkg holds SETS, WAYS, TAG_W, and the derived IDX_W=6, WAY_W=3, and TAG_ALL_W=352. The same constants are used by the lookup stage and the controller.
- Sub-module icache_meta_flush_fsm holds the state, counter, busy and flush_done logic. It exports the current sweep index and a sweep-write strobe.
- Storage, write arbitration and the read/bypass path live in the top module.

## Test plan
- Reset, then read set 5 → rvalid=1 next cycle, valid_rdata=8'h00.
- Refill set 5, way 3, tag 44'hABC; read set 5 → valid_rdata=8'h08, tag_rdata[175:132]=44'hABC.
- Refill set 9, way 7, tag 44'h123 in the same cycle as a read of set 9 → next cycle valid_rdata[7]=1 and tag_rdata[351:308]=44'h123 (bypass).
- Refill and invalidate asserted together (set 2 way 0, set 4 way 1) → inv2meta_ready=0 that cycle, 1 the next. Afterwards set 2 valid=8'h01 and set 4 way 1 valid=0.
- Fill ways 0–7 of sets 0 and 63; pulse flush_req in cycle N →
  - busy high for 64 cycles and flush_done in cycle N+64.
  - Reads are refused while busy.
  - After the flush, sets 0 and 63 read valid_rdata=8'h00 with tags unchanged.
- Assert reset at sweep count 20 → busy=0 and flush_done never pulses. Every set then reads valid_rdata=0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry constants for the instruction cache: lookup stage, controller and metadata store.
package icache_pkg;

  localparam int unsigned SETS      = 64;
  localparam int unsigned WAYS      = 8;
  localparam int unsigned TAG_W     = 44;
  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned WAY_W     = $clog2(WAYS);
  localparam int unsigned TAG_ALL_W = WAYS * TAG_W;

  // One set's tags; way w occupies bits [TAG_W*w +: TAG_W]
  typedef logic [WAYS-1:0][TAG_W-1:0] tag_row_t;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_SWEEP = 1'b1
  } flush_state_e;

endpackage

// File: rtl/icache_meta_flush_fsm.sv
// Full-cache flush sequencer: walks every set once, one set per cycle, and
// reports busy for the duration plus a done pulse on the final set.
module icache_meta_flush_fsm
  import icache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done,
  output logic             sweep_wen,
  output logic [IDX_W-1:0] sweep_index,
  output logic             flush_start_c
);

  flush_state_e     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             busy_d, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FL_IDLE;
      cnt_q      <= '0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      flush_done <= done_d;
    end
  end

  // Registered outputs are derived from next-state so they line up with the sweep cycle
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_start_c = 1'b0;
    case (state_q)
      FL_IDLE: begin
        if (flush_req) begin
          state_d       = FL_SWEEP;
          cnt_d         = '0;
          flush_start_c = 1'b1;
        end
      end
      FL_SWEEP: begin
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = FL_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = FL_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == FL_SWEEP);
    done_d = (state_d == FL_SWEEP) && (cnt_d == IDX_W'(SETS - 1));
  end

  assign sweep_wen   = (state_q == FL_SWEEP);
  assign sweep_index = cnt_q;

endmodule

// File: rtl/icache_meta_array.sv
// Tag/valid metadata store for the 8-way instruction cache: one-cycle set reads with
// same-cycle write bypass, refill/invalidate writes, and a sequenced full flush.
module icache_meta_array
  import icache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lookup2meta_valid,
  input  logic [IDX_W-1:0]     lookup2meta_index,
  input  logic                 lookup2meta_ready,
  output logic                 meta2lookup_rvalid,
  output logic [WAYS-1:0]      meta2lookup_valid_rdata,
  output logic [TAG_ALL_W-1:0] meta2lookup_tag_rdata,
  output logic                 meta2lookup_busy,
  input  logic                 refill2meta_wen,
  input  logic [IDX_W-1:0]     refill2meta_index,
  input  logic [WAY_W-1:0]     refill2meta_way,
  input  logic [TAG_W-1:0]     refill2meta_tag,
  input  logic                 inv2meta_en,
  input  logic [IDX_W-1:0]     inv2meta_index,
  input  logic [WAY_W-1:0]     inv2meta_way,
  output logic                 inv2meta_ready,
  input  logic                 flush_req,
  output logic                 flush_done
);

  logic [WAYS-1:0]  valid_q [SETS];
  tag_row_t         tag_q   [SETS];

  logic             sweep_wen;
  logic [IDX_W-1:0] sweep_index;
  logic             flush_start_c;
  logic             busy;

  logic             refill_do, inv_do, rd_accept;
  logic [WAYS-1:0]  rd_valid_row;
  tag_row_t         rd_tag_row;

  icache_meta_flush_fsm u_flush (
    .clock         (clock),
    .reset         (reset),
    .flush_req     (flush_req),
    .busy          (busy),
    .flush_done    (flush_done),
    .sweep_wen     (sweep_wen),
    .sweep_index   (sweep_index),
    .flush_start_c (flush_start_c)
  );

  assign meta2lookup_busy = busy;

  // Write arbitration: sweep > refill > invalidate
  assign refill_do      = refill2meta_wen && !busy;
  assign inv_do         = inv2meta_en && !refill2meta_wen && !busy && !reset;
  assign inv2meta_ready = inv_do;
  assign rd_accept      = lookup2meta_valid && lookup2meta_ready && !busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (sweep_wen) begin
      valid_q[sweep_index] <= '0;
    end else if (refill_do) begin
      valid_q[refill2meta_index][refill2meta_way] <= 1'b1;
    end else if (inv_do) begin
      valid_q[inv2meta_index][inv2meta_way] <= 1'b0;
    end
  end

  // Tag storage carries no reset; only the valid bits qualify it
  always_ff @(posedge clock) begin
    if (refill_do) begin
      tag_q[refill2meta_index][refill2meta_way] <= refill2meta_tag;
    end
  end

  // Post-write view of the set being read, so a same-cycle write is visible
  always_comb begin
    rd_valid_row = valid_q[lookup2meta_index];
    rd_tag_row   = tag_q[lookup2meta_index];
    if (sweep_wen && (sweep_index == lookup2meta_index)) begin
      rd_valid_row = '0;
    end else if (refill_do && (refill2meta_index == lookup2meta_index)) begin
      rd_valid_row[refill2meta_way] = 1'b1;
      rd_tag_row[refill2meta_way]   = refill2meta_tag;
    end else if (inv_do && (inv2meta_index == lookup2meta_index)) begin
      rd_valid_row[inv2meta_way] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta2lookup_rvalid      <= 1'b0;
      meta2lookup_valid_rdata <= '0;
      meta2lookup_tag_rdata   <= '0;
    end else begin
      if (flush_start_c) begin
        meta2lookup_rvalid <= 1'b0;
      end else if (rd_accept) begin
        meta2lookup_rvalid <= 1'b1;
      end
      if (rd_accept) begin
        meta2lookup_valid_rdata <= rd_valid_row;
        meta2lookup_tag_rdata   <= rd_tag_row;
      end
    end
  end

endmodule

// File: tb/tb_icache_meta_array.sv
// Directed scoreboard bench for icache_meta_array: expected read results are queued
// by the driver and popped by a monitor whenever a read is accepted.
module tb_icache_meta_array;
  import icache_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         lv = 1'b0, lr = 1'b1;
  logic [5:0]   li = '0;
  logic         rvalid, busy, inv_ready, done;
  logic [7:0]   vdata;
  logic [351:0] tdata;
  logic         wen = 1'b0;
  logic [5:0]   ri = '0;
  logic [2:0]   rw = '0;
  logic [43:0]  rt = '0;
  logic         ie = 1'b0;
  logic [5:0]   ii = '0;
  logic [2:0]   iw = '0;
  logic         freq = 1'b0;

  always #5 clock = ~clock;

  icache_meta_array dut (
    .clock                   (clock),
    .reset                   (reset),
    .lookup2meta_valid       (lv),
    .lookup2meta_index       (li),
    .lookup2meta_ready       (lr),
    .meta2lookup_rvalid      (rvalid),
    .meta2lookup_valid_rdata (vdata),
    .meta2lookup_tag_rdata   (tdata),
    .meta2lookup_busy        (busy),
    .refill2meta_wen         (wen),
    .refill2meta_index       (ri),
    .refill2meta_way         (rw),
    .refill2meta_tag         (rt),
    .inv2meta_en             (ie),
    .inv2meta_index          (ii),
    .inv2meta_way            (iw),
    .inv2meta_ready          (inv_ready),
    .flush_req               (freq),
    .flush_done              (done)
  );

  typedef struct {
    logic [7:0]   v;
    logic [7:0]   tmask;
    logic [351:0] t;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic pend  = 1'b0;

  task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [351:0] tw(input int w, input logic [43:0] t);
    logic [351:0] r;
    r = '0;
    r[w*44 +: 44] = t;
    return r;
  endfunction

  // Monitor: a read accepted at the previous edge is checked against the queue head
  always @(negedge clock) begin
    exp_t e;
    if (pend) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_read: got read of set %0h, expected none", li);
      end else begin
        e = q.pop_front();
        check("rvalid", rvalid, 1'b1);
        check("valid_rdata", vdata, e.v);
        for (int w = 0; w < 8; w++) begin
          if (e.tmask[w]) check($sformatf("tag_way%0d", w), tdata[w*44 +: 44], e.t[w*44 +: 44]);
        end
      end
    end
    pend = lv && lr && !busy && !reset;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    lv = 1'b0; lr = 1'b1; li = '0;
    wen = 1'b0; ri = '0; rw = '0; rt = '0;
    ie = 1'b0; ii = '0; iw = '0;
    freq = 1'b0;
  endtask

  task automatic rd(input logic [5:0] idx, input logic [7:0] v, input logic [7:0] m,
                    input logic [351:0] t);
    exp_t e;
    cyc();
    clr();
    lv = 1'b1;
    li = idx;
    e.v = v; e.tmask = m; e.t = t;
    q.push_back(e);
  endtask

  task automatic rf(input logic [5:0] idx, input logic [2:0] way, input logic [43:0] tag);
    cyc();
    clr();
    wen = 1'b1; ri = idx; rw = way; rt = tag;
  endtask

  logic [351:0] row0, row63;

  initial begin
    row0  = '0;
    row63 = '0;
    for (int w = 0; w < 8; w++) begin
      row0  = row0  | tw(w, 44'h100 + 44'(w));
      row63 = row63 | tw(w, 44'h6300 + 44'(w));
    end

    // Reset state, with an invalidate pending that must not be acknowledged
    clr();
    ie = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_valid_rdata", vdata, 8'h00);
    check("rst_tag_rdata", tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_flush_done", done, 1'b0);
    check("rst_inv_ready", inv_ready, 1'b0);
    cyc();
    reset = 1'b0;
    clr();

    // Empty set read, then refill and read back
    rd(6'd5, 8'h00, 8'h00, '0);
    rf(6'd5, 3'd3, 44'hABC);
    rd(6'd5, 8'h08, 8'h08, tw(3, 44'hABC));

    // Held valid with ready low must not be accepted
    cyc(); clr(); lv = 1'b1; li = 6'd5; lr = 1'b0;

    // Same-cycle refill/read bypass
    rd(6'd9, 8'h80, 8'h80, tw(7, 44'h123));
    wen = 1'b1; ri = 6'd9; rw = 3'd7; rt = 44'h123;

    // Refill beats invalidate; invalidate accepted the following cycle
    rf(6'd4, 3'd1, 44'h44);
    cyc(); clr();
    wen = 1'b1; ri = 6'd2; rw = 3'd0; rt = 44'h22;
    ie = 1'b1; ii = 6'd4; iw = 3'd1;
    @(negedge clock);
    check("inv_ready_blocked", inv_ready, 1'b0);
    cyc(); clr();
    ie = 1'b1; ii = 6'd4; iw = 3'd1;
    @(negedge clock);
    check("inv_ready_granted", inv_ready, 1'b1);
    rd(6'd2, 8'h01, 8'h01, tw(0, 44'h22));
    rd(6'd4, 8'h00, 8'h00, '0);
    rd(6'd4, 8'h00, 8'h02, tw(1, 44'h44));

    // Full flush with sets 0 and 63 fully populated
    for (int w = 0; w < 8; w++) begin
      rf(6'd0, 3'(w), 44'h100 + 44'(w));
      rf(6'd63, 3'(w), 44'h6300 + 44'(w));
    end
    rd(6'd0, 8'hFF, 8'hFF, row0);
    cyc(); clr();
    freq = 1'b1;
    @(negedge clock);
    check("flush_busy_at_req", busy, 1'b0);
    for (int k = 1; k <= 66; k++) begin
      exp_t e;
      cyc(); clr();
      if (k <= 64) begin
        lv = 1'b1;
        li = 6'd0;
        if (k == 10) freq = 1'b1;
      end else if (k == 65) begin
        lv = 1'b1;
        li = 6'd0;
        e.v = 8'h00; e.tmask = 8'hFF; e.t = row0;
        q.push_back(e);
      end
      @(negedge clock);
      check($sformatf("flush_busy_k%0d", k), busy, (k <= 64));
      check($sformatf("flush_done_k%0d", k), done, (k == 64));
      if (k <= 64) check($sformatf("flush_rvalid_k%0d", k), rvalid, 1'b0);
    end
    rd(6'd63, 8'h00, 8'hFF, row63);
    rd(6'd5, 8'h00, 8'h08, tw(3, 44'hABC));
    rd(6'd9, 8'h00, 8'h00, '0);

    // Reset while the sweep is at set 20
    rf(6'd40, 3'd2, 44'h40);
    rd(6'd40, 8'h04, 8'h04, tw(2, 44'h40));
    cyc(); clr();
    freq = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc(); clr();
    end
    reset = 1'b1;
    cyc(); clr();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rvalid", rvalid, 1'b0);
    for (int k = 0; k < 70; k++) begin
      cyc(); clr();
      @(negedge clock);
      check($sformatf("midrst_done_c%0d", k), done, 1'b0);
      check($sformatf("midrst_busy_c%0d", k), busy, 1'b0);
    end
    for (int s = 0; s < 64; s++) begin
      rd(6'(s), 8'h00, 8'h00, '0);
    end

    cyc(); clr();
    repeat (3) cyc();
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
